// File: rtl/c432_lock_pkg.sv
// Shared definitions for the c432 key loader and the benches that drive it.
package c432_lock_pkg;

    // Width of the unlock key; bit i drives keyinput<i> of the locked netlist.
    localparam int KEY_W = 32;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        COMMIT = 3'd3,
        ERROR  = 3'd4
    } key_ld_state_e;

    // Key that unlocks the c432 netlist (used by the oracle bench).
    localparam logic [KEY_W-1:0] C432_CORRECT_KEY = 32'hA5C3_0F1E;

endpackage

// File: rtl/c432_key_loader_if.sv
// Serial key load handshake and active-key outputs of the c432 key loader.
interface c432_key_loader_if #(
    parameter int KEY_W = c432_lock_pkg::KEY_W
);
    logic             load_start;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             load_done;
    logic             load_err;

    // Key source side: starts loads and presents serial bits.
    modport master (
        output load_start, ser_valid, ser_data,
        input  ser_ready, key_out, key_valid, busy, load_done, load_err
    );

    // Loader side.
    modport slave (
        input  load_start, ser_valid, ser_data,
        output ser_ready, key_out, key_valid, busy, load_done, load_err
    );
endinterface

// File: rtl/key_shift_par.sv
// Shadow shift register for the incoming key with running parity and bit count.
// Bits arrive LSB first and enter at the top, so after KEY_W shifts the first
// bit sits in bit 0.
module key_shift_par #(
    parameter int KEY_W = c432_lock_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             ser_data,
    output logic [KEY_W-1:0] shadow,
    output logic             par,
    output logic             cnt_full
);
    localparam int CW = $clog2(KEY_W + 1);

    logic [CW-1:0] cnt;

    // Shift in accepted bits, fold them into the parity and count them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            par    <= 1'b0;
            cnt    <= '0;
        end else if (clr) begin
            shadow <= '0;
            par    <= 1'b0;
            cnt    <= '0;
        end else if (shift_en) begin
            shadow <= {ser_data, shadow[KEY_W-1:1]};
            par    <= par ^ ser_data;
            cnt    <= cnt + 1'b1;
        end
    end

    // High while the next accepted bit is the last key bit.
    assign cnt_full = (cnt == CW'(KEY_W - 1));

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 netlist: collects KEY_W bits plus an
// even-parity bit and only then updates the registered active key.
//
// state  | meaning
// IDLE   | waiting for load_start
// SHIFT  | accepting key bits
// PARITY | accepting the parity bit
// COMMIT | parity good, active key updates at the end of this cycle
// ERROR  | parity bad or timeout, load discarded
module c432_key_loader #(
    parameter int               KEY_W       = c432_lock_pkg::KEY_W,
    parameter logic [KEY_W-1:0] DEFAULT_KEY = '0,
    parameter int               TIMEOUT     = 16
) (
    input logic              clk,
    input logic              rst_n,
    c432_key_loader_if.slave bus
);
    import c432_lock_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    key_ld_state_e    state, state_nxt;
    logic [TW-1:0]    tcnt;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] key_q;
    logic             key_valid_q;
    logic             par;
    logic             cnt_full;
    logic             shift_en;
    logic             clr;
    logic             tcnt_clr;
    logic             tcnt_inc;
    logic             commit;
    logic             ser_ready_c;
    logic             busy_c;
    logic             done_c;
    logic             err_c;
    logic             timed_out;

    key_shift_par #(.KEY_W(KEY_W)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clr      (clr),
        .ser_data (bus.ser_data),
        .shadow   (shadow),
        .par      (par),
        .cnt_full (cnt_full)
    );

    // The idle cycle that brings the count up to TIMEOUT aborts the load.
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control decode; load_start outranks bit acceptance.
    always_comb begin
        state_nxt   = state;
        ser_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        err_c       = 1'b0;
        shift_en    = 1'b0;
        clr         = 1'b0;
        tcnt_clr    = 1'b0;
        tcnt_inc    = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_nxt = SHIFT;
                    clr       = 1'b1;
                    tcnt_clr  = 1'b1;
                end
            end
            SHIFT: begin
                ser_ready_c = 1'b1;
                busy_c      = 1'b1;
                if (bus.load_start) begin
                    state_nxt = SHIFT;
                    clr       = 1'b1;
                    tcnt_clr  = 1'b1;
                end else if (bus.ser_valid) begin
                    shift_en = 1'b1;
                    tcnt_clr = 1'b1;
                    if (cnt_full) state_nxt = PARITY;
                end else if (timed_out) begin
                    state_nxt = ERROR;
                    tcnt_clr  = 1'b1;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            PARITY: begin
                ser_ready_c = 1'b1;
                busy_c      = 1'b1;
                if (bus.load_start) begin
                    state_nxt = SHIFT;
                    clr       = 1'b1;
                    tcnt_clr  = 1'b1;
                end else if (bus.ser_valid) begin
                    tcnt_clr  = 1'b1;
                    state_nxt = (bus.ser_data == par) ? COMMIT : ERROR;
                end else if (timed_out) begin
                    state_nxt = ERROR;
                    tcnt_clr  = 1'b1;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            COMMIT: begin
                done_c    = 1'b1;
                commit    = 1'b1;
                clr       = 1'b1;
                state_nxt = IDLE;
            end
            ERROR: begin
                err_c     = 1'b1;
                clr       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                clr       = 1'b1;
                tcnt_clr  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Idle-cycle timeout counter, cleared on every accepted bit and on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tcnt <= '0;
        else if (tcnt_clr) tcnt <= '0;
        else if (tcnt_inc) tcnt <= tcnt + 1'b1;
    end

    // Active key register; the shadow is read here before it clears on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= DEFAULT_KEY;
            key_valid_q <= 1'b0;
        end else if (commit) begin
            key_q       <= shadow;
            key_valid_q <= 1'b1;
        end
    end

    assign bus.ser_ready = ser_ready_c;
    assign bus.busy      = busy_c;
    assign bus.load_done = done_c;
    assign bus.load_err  = err_c;
    assign bus.key_out   = key_q;
    assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Bench for c432_key_loader: directed scenarios plus random traffic, checked
// every cycle against a load-level reference model.
module tb_c432_key_loader;

    localparam int KW  = 32;
    localparam int TMO = 16;

    logic clk;
    logic rst_n;

    c432_key_loader_if #(.KEY_W(KW)) bus ();

    c432_key_loader #(
        .KEY_W       (KW),
        .DEFAULT_KEY (32'h0),
        .TIMEOUT     (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load collects bits into cand; once KEY_W bits are in,
    // the next bit decides commit/error; TMO idle cycles in a row abort it.
    logic          m_in_load;
    logic          m_done;
    logic          m_err;
    logic [31:0]   m_key;
    logic          m_kv;
    logic [31:0]   m_cand;
    int            m_nbits;
    int            m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_load <= 1'b0;
            m_done    <= 1'b0;
            m_err     <= 1'b0;
            m_key     <= 32'h0;
            m_kv      <= 1'b0;
            m_cand    <= 32'h0;
            m_nbits   <= 0;
            m_idle    <= 0;
        end else if (m_done || m_err) begin
            if (m_done) begin
                m_key <= m_cand;
                m_kv  <= 1'b1;
            end
            m_done <= 1'b0;
            m_err  <= 1'b0;
        end else if (bus.load_start) begin
            m_in_load <= 1'b1;
            m_cand    <= 32'h0;
            m_nbits   <= 0;
            m_idle    <= 0;
        end else if (m_in_load) begin
            if (bus.ser_valid) begin
                m_idle <= 0;
                if (m_nbits < KW) begin
                    m_cand[m_nbits] <= bus.ser_data;
                    m_nbits         <= m_nbits + 1;
                end else begin
                    m_in_load <= 1'b0;
                    if (bus.ser_data == ^m_cand) m_done <= 1'b1;
                    else                         m_err  <= 1'b1;
                end
            end else begin
                m_idle <= m_idle + 1;
                if (m_idle + 1 == TMO) begin
                    m_in_load <= 1'b0;
                    m_err     <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("ser_ready", {31'b0, bus.ser_ready}, {31'b0, m_in_load});
        check("busy",      {31'b0, bus.busy},      {31'b0, m_in_load});
        check("load_done", {31'b0, bus.load_done}, {31'b0, m_done});
        check("load_err",  {31'b0, bus.load_err},  {31'b0, m_err});
        check("key_out",   bus.key_out,            m_key);
        check("key_valid", {31'b0, bus.key_valid}, {31'b0, m_kv});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            bus.ser_data = 1'($urandom);
            tick();
        end
        bus.ser_valid = 1'b1;
        bus.ser_data  = b;
        tick();
        bus.ser_valid = 1'b0;
        bus.ser_data  = 1'($urandom);
    endtask

    task automatic send_bits(input logic [31:0] k, input int n, input int max_gap);
        for (int i = 0; i < n; i++) send_bit(k[i], max_gap);
    endtask

    initial begin
        logic [31:0] k;
        logic        p;
        int          mode;

        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.ser_valid  = 1'b0;
        bus.ser_data   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset then idle: default key, nothing valid, no pulses.
        repeat (10) tick();
        check("rst_key", bus.key_out, 32'h0);
        check("rst_kv", {31'b0, bus.key_valid}, 32'h0);
        check("rst_ready", {31'b0, bus.ser_ready}, 32'h0);

        // Good key with even parity bit 0.
        k = 32'hA5C3_0F1E;
        pulse_start();
        send_bits(k, 32, 0);
        send_bit(1'b0, 0);
        check("done_pulse", {31'b0, bus.load_done}, 32'h1);
        tick();
        check("key_a5", bus.key_out, 32'hA5C3_0F1E);
        check("model_a5", m_key, 32'hA5C3_0F1E);
        check("kv_a5", {31'b0, bus.key_valid}, 32'h1);
        check("done_once", {31'b0, bus.load_done}, 32'h0);

        // Same key with the wrong parity bit.
        pulse_start();
        send_bits(k, 32, 0);
        send_bit(1'b1, 0);
        check("par_err", {31'b0, bus.load_err}, 32'h1);
        tick();
        check("key_kept_par", bus.key_out, 32'hA5C3_0F1E);
        check("kv_kept_par", {31'b0, bus.key_valid}, 32'h1);

        // 20 bits then TMO idle cycles: error on the following cycle.
        pulse_start();
        send_bits(32'h1357_9BDF, 20, 0);
        repeat (TMO - 1) tick();
        check("no_early_err", {31'b0, bus.load_err}, 32'h0);
        tick();
        check("tmo_err", {31'b0, bus.load_err}, 32'h1);
        check("tmo_busy", {31'b0, bus.busy}, 32'h0);
        tick();
        check("key_kept_tmo", bus.key_out, 32'hA5C3_0F1E);

        // Partial all-ones load, restart with a bit presented, then key 1.
        pulse_start();
        send_bits(32'hFFFF_FFFF, 10, 0);
        bus.ser_valid = 1'b1;
        bus.ser_data  = 1'b1;
        pulse_start();
        bus.ser_valid = 1'b0;
        send_bits(32'h0000_0001, 32, 0);
        send_bit(1'b1, 0);
        tick();
        check("key_restart", bus.key_out, 32'h0000_0001);

        // Random loads: gaps, bad parity, restarts, timeouts, stray bits.
        for (int n = 0; n < 30; n++) begin
            k    = $urandom;
            mode = int'($urandom_range(0, 9));
            p    = ^k;
            if (mode == 0) p = ~p;
            bus.ser_valid = 1'($urandom);
            bus.ser_data  = 1'($urandom);
            pulse_start();
            bus.ser_valid = 1'b0;
            if (mode == 1) begin
                send_bits(~k, int'($urandom_range(0, 33)), 2);
                pulse_start();
            end
            if (mode == 2) begin
                send_bits(k, int'($urandom_range(0, 32)), 1);
                repeat (TMO + 2) tick();
            end else begin
                send_bits(k, 32, (mode == 3) ? TMO : 2);
                send_bit(p, 2);
                if (mode == 4) begin
                    bus.load_start = 1'b1;
                    tick();
                    bus.load_start = 1'b0;
                end
                repeat (2) tick();
            end
        end

        // Commit a key, then reset in the middle of the next load.
        k = 32'h1234_5678;
        pulse_start();
        send_bits(k, 32, 0);
        send_bit(^k, 0);
        tick();
        check("key_1234", bus.key_out, 32'h1234_5678);
        pulse_start();
        send_bits(32'hFFFF_0000, 17, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_key", bus.key_out, 32'h0);
        check("async_kv", {31'b0, bus.key_valid}, 32'h0);
        check("async_busy", {31'b0, bus.busy}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_key", bus.key_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
